// File: rtl/pair_triple_monitor_pkg.sv
// Shared types and helpers for the pair/triple monitor: FSM state encoding and
// a width-aware saturating increment.
package pair_triple_monitor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StAlarm = 2'd2;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 31).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_val;
    max_val = (32'd1 << w) - 32'd1;
    return (v >= max_val) ? max_val : v + 32'd1;
  endfunction

endpackage

// File: rtl/pair_triple_monitor_det.sv
// Gate-level 2-of-3 majority detector; the AND/OR form keeps the usual
// x-propagation (known when two inputs already decide the result).
module pair_triple_monitor_det (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic det
);

  assign det = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/pair_triple_monitor.sv
// Counts consecutive and total majority detections and raises a registered
// alarm once the consecutive run reaches RUN_LEN.
module pair_triple_monitor
  import pair_triple_monitor_pkg::*;
#(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  output logic             det,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] total_count,
  output logic             alarm,
  output logic             alarm_rise
);

  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] total_q, total_d;
  state_t           state_q, state_d;
  logic             alarm_q, alarm_d;
  logic             rise_q, rise_d;

  pair_triple_monitor_det u_det (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .det (det)
  );

  always_comb begin
    run_d   = run_q;
    total_d = total_q;
    state_d = state_q;
    alarm_d = alarm_q;
    rise_d  = rise_q;
    if (clear) begin
      run_d   = '0;
      total_d = '0;
      state_d = StIdle;
      alarm_d = 1'b0;
      rise_d  = 1'b0;
    end else if (en) begin
      if (det) begin
        run_d   = CNT_W'(sat_inc(32'(run_q), CNT_W));
        total_d = CNT_W'(sat_inc(32'(total_q), CNT_W));
      end else begin
        run_d = '0;
      end
      // State follows the next run count, so it never steps back from ALARM to RUN.
      if (run_d == '0) begin
        state_d = StIdle;
      end else if (32'(run_d) < RUN_LEN) begin
        state_d = StRun;
      end else begin
        state_d = StAlarm;
      end
      alarm_d = (state_d == StAlarm);
      rise_d  = (state_d == StAlarm) && (state_q != StAlarm);
    end else begin
      rise_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      total_q <= '0;
      state_q <= StIdle;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      total_q <= total_d;
      state_q <= state_d;
      alarm_q <= alarm_d;
      rise_q  <= rise_d;
    end
  end

  assign run_count   = run_q;
  assign total_count = total_q;
  assign alarm       = alarm_q;
  assign alarm_rise  = rise_q;

endmodule
